bus_datapath_gen: RTL and testbench

//  Parametrised single-bus MINI SRC datapath: NUM_REGS x DATA_W register file, HI/LO, Y, Z,
//  PC, IR, MAR/MDR, in/out ports, IR field decode, one-hot bus arbitration with conflict

---
 rtl/bus_datapath_gen.sv | 205 ++++++++++++++++++++
 tb/tb_bus_datapath_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_datapath_gen.sv
// Single-bus MINI SRC datapath: register file, special registers, IR decode, bus arbitration and memory port FSM.
// Optional build macro MEM_TIMEOUT_EN adds a bounded wait for mem_ready and the sticky mem_err flag.
module bus_datapath_gen #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 9,
    parameter int TIMEOUT  = 15
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  Gra,
    input  logic                  Grb,
    input  logic                  Grc,
    input  logic                  Rin,
    input  logic                  Rout,
    input  logic                  BAout,
    input  logic                  Yin,
    input  logic                  HIin,
    input  logic                  LOin,
    input  logic                  Zin,
    input  logic                  PCin,
    input  logic                  IRin,
    input  logic                  MARin,
    input  logic                  MDRin,
    input  logic                  OutPortIn,
    input  logic                  HIout,
    input  logic                  LOout,
    input  logic                  Zhighout,
    input  logic                  Zlowout,
    input  logic                  PCout,
    input  logic                  MDRout,
    input  logic                  Cout,
    input  logic                  InPortOut,
    input  logic                  IncPC,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [2*DATA_W-1:0]   alu_result,
    input  logic [DATA_W-1:0]     in_port,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic [DATA_W-1:0]     bus_out,
    output logic [DATA_W-1:0]     y_out,
    output logic [DATA_W-1:0]     ir_out,
    output logic [DATA_W-1:0]     out_port,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic                  mem_busy,
    output logic                  bus_conflict,
    output logic                  mem_err
);
    localparam int RIDX_W = $clog2(NUM_REGS);
    localparam int C_W    = DATA_W - 6 - 2*RIDX_W;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] hi, lo, y, z_hi, z_lo, pc, ir, mdr, in_reg, out_reg;
    logic [ADDR_W-1:0] mar;
    logic [RIDX_W-1:0] ra, rb, rc, sel;
    logic [DATA_W-1:0] reg_val, c_ext, bus_mux, bus_val;
    logic [3:0]        n_src;
    logic              multi, conflict_q, mem_rd_q, mem_wr_q;
    state_t            state;

    function automatic logic [DATA_W-1:0] sign_ext(input logic signed [C_W-1:0] c);
        return {{(DATA_W-C_W){c[C_W-1]}}, c};
    endfunction

    assign ra      = ir[DATA_W-6 -: RIDX_W];
    assign rb      = ir[DATA_W-6-RIDX_W -: RIDX_W];
    assign rc      = ir[DATA_W-6-2*RIDX_W -: RIDX_W];
    assign sel     = ({RIDX_W{Gra}} & ra) | ({RIDX_W{Grb}} & rb) | ({RIDX_W{Grc}} & rc);
    assign reg_val = regs[sel];
    assign c_ext   = sign_ext(ir[C_W-1:0]);

    // Bus: OR of enabled sources, forced to zero when more than one drives
    always_comb begin
        bus_mux = '0;
        n_src   = '0;
        if (Rout)      begin bus_mux = bus_mux | reg_val;                            n_src = n_src + 4'd1; end
        if (BAout)     begin bus_mux = bus_mux | ((sel == '0) ? '0 : reg_val);       n_src = n_src + 4'd1; end
        if (HIout)     begin bus_mux = bus_mux | hi;                                 n_src = n_src + 4'd1; end
        if (LOout)     begin bus_mux = bus_mux | lo;                                 n_src = n_src + 4'd1; end
        if (Zhighout)  begin bus_mux = bus_mux | z_hi;                               n_src = n_src + 4'd1; end
        if (Zlowout)   begin bus_mux = bus_mux | z_lo;                               n_src = n_src + 4'd1; end
        if (PCout)     begin bus_mux = bus_mux | pc;                                 n_src = n_src + 4'd1; end
        if (MDRout)    begin bus_mux = bus_mux | mdr;                                n_src = n_src + 4'd1; end
        if (Cout)      begin bus_mux = bus_mux | c_ext;                              n_src = n_src + 4'd1; end
        if (InPortOut) begin bus_mux = bus_mux | in_reg;                             n_src = n_src + 4'd1; end
        multi   = (n_src > 4'd1);
        bus_val = multi ? '0 : bus_mux;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            hi         <= '0;
            lo         <= '0;
            y          <= '0;
            z_hi       <= '0;
            z_lo       <= '0;
            pc         <= '0;
            ir         <= '0;
            mar        <= '0;
            mdr        <= '0;
            in_reg     <= '0;
            out_reg    <= '0;
            conflict_q <= 1'b0;
        end else begin
            if (Rin)       regs[sel] <= bus_val;
            if (Yin)       y         <= bus_val;
            if (HIin)      hi        <= bus_val;
            if (LOin)      lo        <= bus_val;
            if (IRin)      ir        <= bus_val;
            if (OutPortIn) out_reg   <= bus_val;
            if (Zin) begin
                z_hi <= alu_result[2*DATA_W-1:DATA_W];
                z_lo <= alu_result[DATA_W-1:0];
            end
            if (PCin)       pc <= bus_val;
            else if (IncPC) pc <= pc + 1'b1;
            // Address and write data are frozen for the duration of a transfer
            if (MARin && state == IDLE) mar <= bus_val[ADDR_W-1:0];
            if (state == RD_WAIT && mem_ready)  mdr <= mem_rdata;
            else if (MDRin && state != WR_WAIT) mdr <= bus_val;
            in_reg     <= in_port;
            conflict_q <= conflict_q | multi;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt;
    logic             err_q;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt      <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef MEM_TIMEOUT_EN
                    cnt <= '0;
`endif
                    if (memRead) begin
                        state    <= RD_WAIT;
                        mem_rd_q <= 1'b1;
                    end else if (memWrite) begin
                        state    <= WR_WAIT;
                        mem_wr_q <= 1'b1;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (mem_ready) begin
                        state    <= IDLE;
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (cnt == CNT_LAST) begin
                        state    <= IDLE;
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        err_q    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state    <= IDLE;
                    mem_rd_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign bus_out      = bus_val;
    assign y_out        = y;
    assign ir_out       = ir;
    assign out_port     = out_reg;
    assign mem_addr     = mar;
    assign mem_wdata    = mdr;
    assign mem_rd       = mem_rd_q;
    assign mem_wr       = mem_wr_q;
    assign mem_busy     = (state != IDLE);
    assign bus_conflict = conflict_q;
endmodule

// File: tb/tb_bus_datapath_gen.sv
// Scoreboard bench for bus_datapath_gen: expectations queued at stimulus time, popped at observation.
// Covers the MEM_TIMEOUT_EN path when that macro is defined, the unbounded wait otherwise.
module tb_bus_datapath_gen;
    localparam int DATA_W = 32, NUM_REGS = 16, ADDR_W = 9, TIMEOUT = 15;

    logic clock = 1'b0, clear;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic Yin, HIin, LOin, Zin, PCin, IRin, MARin, MDRin, OutPortIn;
    logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout, InPortOut;
    logic IncPC, memRead, memWrite, mem_ready;
    logic [2*DATA_W-1:0] alu_result;
    logic [DATA_W-1:0]   in_port, mem_rdata;
    logic [DATA_W-1:0]   bus_out, y_out, ir_out, out_port, mem_wdata;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd, mem_wr, mem_busy, bus_conflict, mem_err;

    bus_datapath_gen #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .clear(clear), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .Yin(Yin), .HIin(HIin), .LOin(LOin), .Zin(Zin), .PCin(PCin), .IRin(IRin),
        .MARin(MARin), .MDRin(MDRin), .OutPortIn(OutPortIn), .HIout(HIout), .LOout(LOout),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout), .MDRout(MDRout), .Cout(Cout),
        .InPortOut(InPortOut), .IncPC(IncPC), .memRead(memRead), .memWrite(memWrite),
        .alu_result(alu_result), .in_port(in_port), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_out(bus_out), .y_out(y_out), .ir_out(ir_out), .out_port(out_port),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_busy(mem_busy), .bus_conflict(bus_conflict), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [63:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic idle();
        {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
        {Yin, HIin, LOin, Zin, PCin, IRin, MARin, MDRin, OutPortIn} = '0;
        {HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout, InPortOut} = '0;
        {IncPC, memRead, memWrite} = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Latch a value into the input port register so InPortOut can place it on the bus
    task automatic stage_in(input logic [DATA_W-1:0] v);
        in_port = v;
        step();
    endtask

    task automatic write_sel(input logic [2:0] g, input logic [DATA_W-1:0] v);
        stage_in(v);
        {Gra, Grb, Grc} = g;
        InPortOut = 1'b1;
        Rin = 1'b1;
        step();
        idle();
    endtask

    task automatic read_sel(input logic [2:0] g, input string tag, input logic [DATA_W-1:0] v);
        {Gra, Grb, Grc} = g;
        Rout = 1'b1;
        push_exp(tag, 64'(v));
        #1;
        pop_chk(64'(bus_out));
        idle();
    endtask

    task automatic bus_chk(input string tag, input logic [DATA_W-1:0] v);
        push_exp(tag, 64'(v));
        #1;
        pop_chk(64'(bus_out));
        idle();
    endtask

    localparam logic [31:0] IRV = (32'd5 << 27) | (32'd3 << 23) | (32'd5 << 19) | (32'd7 << 15) | 32'h0ABC;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd_cycles;
        int n;
        idle();
        clear = 1'b0;
        in_port = '0;
        alu_result = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        #12;
        push_exp("rst_bus", 64'd0);  pop_chk(64'(bus_out));
        push_exp("rst_y", 64'd0);    pop_chk(64'(y_out));
        push_exp("rst_ir", 64'd0);   pop_chk(64'(ir_out));
        push_exp("rst_out", 64'd0);  pop_chk(64'(out_port));
        push_exp("rst_rd", 64'd0);   pop_chk(64'(mem_rd));
        push_exp("rst_busy", 64'd0); pop_chk(64'(mem_busy));
        push_exp("rst_conf", 64'd0); pop_chk(64'(bus_conflict));
        push_exp("rst_err", 64'd0);  pop_chk(64'(mem_err));
        @(negedge clock);
        clear = 1'b1;
        step();

        // R0 is writable, but BAout reads it as zero
        write_sel(3'b100, 32'h5);
        Gra = 1'b1; BAout = 1'b1;
        bus_chk("r0_baout", 32'h0);
        read_sel(3'b100, "r0_rout", 32'h5);

        stage_in(IRV);
        InPortOut = 1'b1; IRin = 1'b1;
        push_exp("ir_load", 64'(IRV));
        step();
        idle();
        pop_chk(64'(ir_out));
        Cout = 1'b1;
        bus_chk("c_sext", 32'hFFFF8ABC);

        write_sel(3'b100, 32'h3333_3333);
        write_sel(3'b010, 32'hA5A5_A5A5);
        write_sel(3'b001, 32'h0000_0007);
        read_sel(3'b100, "r3_ra", 32'h3333_3333);
        read_sel(3'b010, "r5_rb", 32'hA5A5_A5A5);
        read_sel(3'b001, "r7_rc", 32'h0000_0007);
        read_sel(3'b110, "or_sel", 32'h0000_0007);

        stage_in(32'h1111_2222);
        InPortOut = 1'b1; Yin = 1'b1;
        push_exp("y_load", 64'h1111_2222);
        step(); idle(); pop_chk(64'(y_out));
        stage_in(32'hAAAA_0001);
        InPortOut = 1'b1; HIin = 1'b1; step(); idle();
        stage_in(32'h5555_0002);
        InPortOut = 1'b1; LOin = 1'b1; OutPortIn = 1'b1;
        push_exp("out_port", 64'h5555_0002);
        step(); idle(); pop_chk(64'(out_port));
        HIout = 1'b1; bus_chk("hi", 32'hAAAA_0001);
        LOout = 1'b1; bus_chk("lo", 32'h5555_0002);

        alu_result = 64'h0123_4567_89AB_CDEF;
        Zin = 1'b1; step(); idle();
        alu_result = '0;
        Zhighout = 1'b1; bus_chk("z_high", 32'h0123_4567);
        Zlowout = 1'b1;  bus_chk("z_low", 32'h89AB_CDEF);

        stage_in(32'hFFFF_FFFF);
        InPortOut = 1'b1; PCin = 1'b1; step(); idle();
        IncPC = 1'b1; step(); idle();
        PCout = 1'b1; bus_chk("pc_wrap", 32'h0);
        stage_in(32'h100);
        InPortOut = 1'b1; PCin = 1'b1; IncPC = 1'b1; step(); idle();
        PCout = 1'b1; bus_chk("pc_prio", 32'h100);
        IncPC = 1'b1; step(); idle();
        PCout = 1'b1; bus_chk("pc_inc", 32'h101);

        // Read with three wait states
        stage_in(32'h01A);
        InPortOut = 1'b1; MARin = 1'b1;
        push_exp("mar", 64'h01A);
        step(); idle(); pop_chk(64'(mem_addr));
        mem_ready = 1'b1; mem_rdata = 32'h5555_5555; step(); mem_ready = 1'b0;
        MDRout = 1'b1; bus_chk("idle_ready", 32'h0);
        memRead = 1'b1; step(); memRead = 1'b0;
        push_exp("rd_busy", 64'd1); pop_chk(64'(mem_busy));
        rd_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_rd) rd_cycles++;
            step();
        end
        if (mem_rd) rd_cycles++;
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        InPortOut = 1'b1; MDRin = 1'b1;
        push_exp("rd_cycles", 64'd4);
        push_exp("rd_done_busy", 64'd0);
        push_exp("rd_done_rd", 64'd0);
        step(); idle(); mem_ready = 1'b0;
        pop_chk(64'(rd_cycles));
        pop_chk(64'(mem_busy));
        pop_chk(64'(mem_rd));
        MDRout = 1'b1; bus_chk("rd_mdr", 32'hDEAD_BEEF);

        memRead = 1'b1; step(); memRead = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        push_exp("zw_busy", 64'd0);
        step(); mem_ready = 1'b0;
        pop_chk(64'(mem_busy));
        MDRout = 1'b1; bus_chk("zw_mdr", 32'hCAFE_F00D);

        // Write, with simultaneous read/write request arbitration
        stage_in(32'h1234);
        InPortOut = 1'b1; MDRin = 1'b1; step(); idle();
        memWrite = 1'b1; memRead = 1'b1;
        push_exp("both_rd", 64'd1); push_exp("both_wr", 64'd0);
        step(); idle();
        pop_chk(64'(mem_rd)); pop_chk(64'(mem_wr));
        mem_ready = 1'b1; mem_rdata = 32'h1234; step(); mem_ready = 1'b0;
        memWrite = 1'b1;
        push_exp("wr_wr", 64'd1); push_exp("wr_data", 64'h1234);
        step(); idle();
        pop_chk(64'(mem_wr)); pop_chk(64'(mem_wdata));
        stage_in(32'h0FF);
        InPortOut = 1'b1; MARin = 1'b1; MDRin = 1'b1; memRead = 1'b1;
        push_exp("busy_mar", 64'h01A); push_exp("busy_mdr", 64'h1234);
        push_exp("busy_wr", 64'd1); push_exp("busy_rd", 64'd0);
        step(); idle();
        pop_chk(64'(mem_addr)); pop_chk(64'(mem_wdata));
        pop_chk(64'(mem_wr)); pop_chk(64'(mem_rd));
        mem_ready = 1'b1;
        push_exp("wr_done", 64'd0);
        step(); mem_ready = 1'b0;
        pop_chk(64'(mem_wr));
        InPortOut = 1'b1; MARin = 1'b1;
        push_exp("idle_mar", 64'h0FF);
        step(); idle(); pop_chk(64'(mem_addr));

        // Asynchronous reset in the middle of a read
        memRead = 1'b1; step(); memRead = 1'b0;
        push_exp("mid_rd", 64'd1); pop_chk(64'(mem_rd));
        #2 clear = 1'b0;
        push_exp("mid_rst_rd", 64'd0);  push_exp("mid_rst_busy", 64'd0);
        push_exp("mid_rst_addr", 64'd0); push_exp("mid_rst_wdata", 64'd0);
        push_exp("mid_rst_y", 64'd0);   push_exp("mid_rst_out", 64'd0);
        #1;
        pop_chk(64'(mem_rd)); pop_chk(64'(mem_busy));
        pop_chk(64'(mem_addr)); pop_chk(64'(mem_wdata));
        pop_chk(64'(y_out)); pop_chk(64'(out_port));
        @(negedge clock);
        clear = 1'b1;
        step();

        PCout = 1'b1; MDRout = 1'b1;
        push_exp("conf_bus", 64'd0); push_exp("conf_pre", 64'd0);
        #1;
        pop_chk(64'(bus_out)); pop_chk(64'(bus_conflict));
        push_exp("conf_set", 64'd1);
        step(); idle();
        pop_chk(64'(bus_conflict));
        push_exp("conf_sticky", 64'd1);
        step(); step();
        pop_chk(64'(bus_conflict));

`ifdef MEM_TIMEOUT_EN
        memRead = 1'b1; step(); memRead = 1'b0;
        n = 0;
        while (mem_busy && n < 40) begin
            n++;
            step();
        end
        push_exp("to_cycles", 64'(TIMEOUT));
        push_exp("to_err", 64'd1);
        pop_chk(64'(n)); pop_chk(64'(mem_err));
        MDRout = 1'b1; bus_chk("to_mdr", 32'h0);
`else
        memRead = 1'b1; step(); memRead = 1'b0;
        n = 0;
        repeat (20) step();
        push_exp("wait_busy", 64'd1); push_exp("wait_err", 64'd0);
        pop_chk(64'(mem_busy)); pop_chk(64'(mem_err));
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        push_exp("wait_done", 64'd0);
        step(); mem_ready = 1'b0;
        pop_chk(64'(mem_busy));
        MDRout = 1'b1; bus_chk("wait_mdr", 32'h0BAD_F00D);
`endif

        check_val("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
